exe_stage: RTL and testbench
============================

Name: exe_stage

Overview:
- Execute stage of the 5-stage in-order pipeline, directly downstream of decode.
- Accepts the decoded bundle and computes the ALU / multiply result in one cycle, or the divide result with an iterative 32-cycle divider.
- Issues the data-SRAM request for loads and stores.
- Forwards its destination and result back to decode, and hands the result bundle to the memory stage under valid/allowin handshake.

Parameters:
- ID_TO_EXE_LEN, 163, decode bundle width: {pc[31:0], gr_we, dest[4:0], rkd_value[31:0], mem_en, alu_op[11:0], src1[31:0], src2[31:0], sl_op[7:0], rfrom_mem, md_op[6:0]}, MSB first.
- EXE_TO_MEM_LEN, 78, output bundle: {pc[31:0], gr_we, dest[4:0], result[31:0], ld_op[4:0], rfrom_mem, addr_lo[1:0]}.
- EXE_RF_LEN, 38, forwarding bus: {dest[4:0], fwd_not_ready, result[31:0]}.

Ports:
- clk  in  1  clock
- reset  in  1  asynchronous, active-high reset
- ID_to_EXE_BUS  in  ID_TO_EXE_LEN  decoded instruction
- ID_to_EXE_valid  in  1  upstream valid
- EXE_allowin  out  1  stage can accept
- MEM_allowin  in  1  downstream can accept
- EXE_to_MEM_valid  out  1  downstream valid
- EXE_to_MEM_BUS  out  EXE_TO_MEM_LEN  result bundle
- EXE_RF_BUS  out  EXE_RF_LEN  forwarding/hazard bus to decode
- data_sram_en  out  1  memory request
- data_sram_we  out  4  byte write enables
- data_sram_addr  out  32  byte address
- data_sram_wdata  out  32  store data

Behaviour:
- Async reset clears:
  - exe_valid, the latched bundle, and all divider registers; divider FSM goes to IDLE.
  - Result: all outputs 0, except EXE_allowin = 1.
- Handshake:
  - EXE_allowin = !exe_valid | (ready_go & MEM_allowin).
  - EXE_to_MEM_valid = exe_valid & ready_go.
  - Bundle latched on ID_to_EXE_valid & EXE_allowin; exe_valid <= ID_to_EXE_valid whenever EXE_allowin.
- Decoded field encodings:
  - sl_op = {st_w, st_b, st_h, ld_w, ld_b, ld_h, ld_bu, ld_hu}.
  - md_op = {mul_w, mulh_w, mulh_wu, div_w, mod_w, div_wu, mod_wu}.
  - alu_op one-hot [0..11] = add, sub, slt, sltu, and, nor, or, xor, sll, srl, sra, lui (result = src2).
- Shifts use src2[4:0]; slt/sltu produce 0/1.
- Result select: div/mod result if any of md_op[3:0]; else mul result if any of md_op[6:4]; else ALU.
  - mul_w = low 32 bits of the product.
  - mulh_w = high 32 bits of the signed 64-bit product.
  - mulh_wu = high 32 bits of the unsigned 64-bit product.
  - Mul is single-cycle.
- ready_go = 1 unless a div/mod is resident and the divider is not in DONE.
- Divider FSM IDLE -> CALC -> DONE:
  - IDLE -> CALC when exe_valid & div/mod op; latch |src1|, |src2| (raw values for unsigned ops), signs, counter = 0.
  - CALC: restoring, one quotient bit per cycle, 32 cycles, then -> DONE.
  - DONE -> IDLE when EXE_to_MEM_valid & MEM_allowin.
  - Latency: instruction arriving at cycle 0 has ready_go = 1 at cycle 33.
  - Signed: quotient negated if signs differ; remainder takes the dividend's sign.
  - Divide by zero: quotient = 32'hFFFF_FFFF, remainder = dividend, still 33 cycles.
  - Signed overflow 0x80000000 / -1: quotient 0x80000000, remainder 0.
  - Reset mid-CALC returns to IDLE; no partial result is visible.
- Memory request:
  - data_sram_en = exe_valid & MEM_allowin & (any sl_op bit). Memory ops are never stalled by the divider.
  - data_sram_addr = ALU sum (src1 + src2).
  - st_w: we = 1111, wdata = rkd.
  - st_h: we = addr[1] ? 1100 : 0011, wdata = {2{rkd[15:0]}}.
  - st_b: we = 0001 << addr[1:0], wdata = {4{rkd[7:0]}}.
  - Loads: we = 0000.
  - Misaligned accesses are not checked.
- EXE_to_MEM_BUS: ld_op = sl_op[4:0]; addr_lo = addr[1:0].
- EXE_RF_BUS:
  - dest = (exe_valid & gr_we) ? dest : 0.
  - fwd_not_ready = rfrom_mem | (div/mod & !DONE).
  - result = the selected result.

Test Plan:
- Basic handshake: valid add, src1 = 5, src2 = 7, MEM_allowin = 1 -> next cycle EXE_to_MEM_valid = 1, result = 12, EXE_RF_BUS = {dest, 0, 12}.
- MEM back-pressure: MEM_allowin = 0 with a valid instruction -> EXE_allowin = 0, bundle held stable; release -> hands off in the same cycle.
- Signed divide: div_w -7 / 2 -> ready_go first at cycle 33, quotient 0xFFFFFFFD; mod_w -7 % 2 -> 0xFFFFFFFF; fwd_not_ready = 1 through cycle 32.
- Divide by zero and reset: div_wu 9 / 0 -> 0xFFFFFFFF at cycle 33; async reset at cycle 10 -> FSM IDLE, exe_valid = 0, EXE_allowin = 1.
- Store lanes: st_b to addr 0x1003, rkd = 0xAB -> en = 1, we = 1000, wdata = 0xABABABAB; st_h to 0x1002 -> we = 1100.
- Multiply: mulh_w 0xFFFFFFFF × 0xFFFFFFFF -> 0; mulh_wu same operands -> 0xFFFFFFFE; mul_w -> 1.

Source files
------------

// File: rtl/exe_stage.sv
// Execute stage: single-cycle ALU/multiply, iterative restoring divider,
// data-SRAM request generation and forwarding back to decode.
`timescale 1ns/1ps
module exe_stage #(
  parameter int ID_TO_EXE_LEN  = 163,
  parameter int EXE_TO_MEM_LEN = 78,
  parameter int EXE_RF_LEN     = 38
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [ID_TO_EXE_LEN-1:0]  ID_to_EXE_BUS,
  input  logic                      ID_to_EXE_valid,
  output logic                      EXE_allowin,
  input  logic                      MEM_allowin,
  output logic                      EXE_to_MEM_valid,
  output logic [EXE_TO_MEM_LEN-1:0] EXE_to_MEM_BUS,
  output logic [EXE_RF_LEN-1:0]     EXE_RF_BUS,
  output logic                      data_sram_en,
  output logic [3:0]                data_sram_we,
  output logic [31:0]               data_sram_addr,
  output logic [31:0]               data_sram_wdata
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_CALC = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  logic                     exe_valid_q, exe_valid_d;
  logic [ID_TO_EXE_LEN-1:0] bus_q, bus_d;
  logic [1:0]               state_q, state_d;
  logic [4:0]               cnt_q, cnt_d;
  logic [31:0]              div_a_q, div_a_d;
  logic [31:0]              div_b_q, div_b_d;
  logic [31:0]              div_r_q, div_r_d;
  logic                     neg_quo_q, neg_quo_d;
  logic                     neg_rem_q, neg_rem_d;
  logic                     dz_q, dz_d;

  logic [31:0] pc_s, rkd_s, src1_s, src2_s;
  logic        gr_we_s, mem_en_s, rfrom_mem_s;
  logic [4:0]  dest_s;
  logic [11:0] alu_op_s;
  logic [7:0]  sl_op_s;
  logic [6:0]  md_op_s;

  assign pc_s        = bus_q[162:131];
  assign gr_we_s     = bus_q[130];
  assign dest_s      = bus_q[129:125];
  assign rkd_s       = bus_q[124:93];
  assign mem_en_s    = bus_q[92];
  assign alu_op_s    = bus_q[91:80];
  assign src1_s      = bus_q[79:48];
  assign src2_s      = bus_q[47:16];
  assign sl_op_s     = bus_q[15:8];
  assign rfrom_mem_s = bus_q[7];
  assign md_op_s     = bus_q[6:0];

  logic is_div_s, is_mul_s, div_signed_s, is_mod_s;
  logic div_done_s, ready_go_s;

  assign is_div_s     = |md_op_s[3:0];
  assign is_mul_s     = |md_op_s[6:4];
  assign div_signed_s = md_op_s[3] | md_op_s[2];
  assign is_mod_s     = md_op_s[2] | md_op_s[0];

  assign ready_go_s       = !(exe_valid_q & is_div_s) | div_done_s;
  assign EXE_allowin      = !exe_valid_q | (ready_go_s & MEM_allowin);
  assign EXE_to_MEM_valid = exe_valid_q & ready_go_s;

  always_comb begin
    exe_valid_d = exe_valid_q;
    bus_d       = bus_q;
    if (EXE_allowin) begin
      exe_valid_d = ID_to_EXE_valid;
      if (ID_to_EXE_valid) begin
        bus_d = ID_to_EXE_BUS;
      end else begin
        bus_d = bus_q;
      end
    end else begin
      exe_valid_d = exe_valid_q;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      exe_valid_q <= 1'b0;
      bus_q       <= '0;
    end else begin
      exe_valid_q <= exe_valid_d;
      bus_q       <= bus_d;
    end
  end

  // ALU: one-hot op select, OR-combined
  logic [31:0] sum_s, sub_s, slt_s, sltu_s, sll_s, srl_s, sra_s, alu_res_s;
  assign sum_s  = src1_s + src2_s;
  assign sub_s  = src1_s - src2_s;
  assign slt_s  = {31'd0, $signed(src1_s) < $signed(src2_s)};
  assign sltu_s = {31'd0, src1_s < src2_s};
  assign sll_s  = src1_s << src2_s[4:0];
  assign srl_s  = src1_s >> src2_s[4:0];
  assign sra_s  = $signed(src1_s) >>> src2_s[4:0];

  assign alu_res_s = ({32{alu_op_s[0]}}  & sum_s)
                   | ({32{alu_op_s[1]}}  & sub_s)
                   | ({32{alu_op_s[2]}}  & slt_s)
                   | ({32{alu_op_s[3]}}  & sltu_s)
                   | ({32{alu_op_s[4]}}  & (src1_s & src2_s))
                   | ({32{alu_op_s[5]}}  & ~(src1_s | src2_s))
                   | ({32{alu_op_s[6]}}  & (src1_s | src2_s))
                   | ({32{alu_op_s[7]}}  & (src1_s ^ src2_s))
                   | ({32{alu_op_s[8]}}  & sll_s)
                   | ({32{alu_op_s[9]}}  & srl_s)
                   | ({32{alu_op_s[10]}} & sra_s)
                   | ({32{alu_op_s[11]}} & src2_s);

  // 64-bit product of sign- or zero-extended operands covers all three mul flavours
  logic [63:0] mul_a_s, mul_b_s, prod_s;
  logic [31:0] mul_res_s;
  assign mul_a_s   = {{32{md_op_s[5] & src1_s[31]}}, src1_s};
  assign mul_b_s   = {{32{md_op_s[5] & src2_s[31]}}, src2_s};
  assign prod_s    = mul_a_s * mul_b_s;
  assign mul_res_s = md_op_s[6] ? prod_s[31:0] : prod_s[63:32];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  state_d = (exe_valid_q & is_div_s) ? S_CALC : S_IDLE;
      S_CALC:  state_d = (cnt_q == 5'd31) ? S_DONE : S_CALC;
      S_DONE:  state_d = (EXE_to_MEM_valid & MEM_allowin) ? S_IDLE : S_DONE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    div_done_s = 1'b0;
    case (state_q)
      S_DONE:  div_done_s = 1'b1;
      default: div_done_s = 1'b0;
    endcase
  end

  // Restoring step: bit 32 of the difference is the borrow, since r < divisor always holds
  logic [32:0] trial_s, diff_s;
  assign trial_s = {div_r_q, div_a_q[31]};
  assign diff_s  = trial_s - {1'b0, div_b_q};

  always_comb begin
    cnt_d     = cnt_q;
    div_a_d   = div_a_q;
    div_b_d   = div_b_q;
    div_r_d   = div_r_q;
    neg_quo_d = neg_quo_q;
    neg_rem_d = neg_rem_q;
    dz_d      = dz_q;
    case (state_q)
      S_IDLE: begin
        if (exe_valid_q & is_div_s) begin
          div_a_d   = (div_signed_s & src1_s[31]) ? (32'd0 - src1_s) : src1_s;
          div_b_d   = (div_signed_s & src2_s[31]) ? (32'd0 - src2_s) : src2_s;
          div_r_d   = 32'd0;
          cnt_d     = 5'd0;
          neg_quo_d = div_signed_s & (src1_s[31] ^ src2_s[31]);
          neg_rem_d = div_signed_s & src1_s[31];
          dz_d      = (src2_s == 32'd0);
        end else begin
          cnt_d = cnt_q;
        end
      end
      S_CALC: begin
        cnt_d   = cnt_q + 5'd1;
        div_r_d = diff_s[32] ? trial_s[31:0] : diff_s[31:0];
        div_a_d = {div_a_q[30:0], ~diff_s[32]};
      end
      default: cnt_d = cnt_q;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_q     <= 5'd0;
      div_a_q   <= 32'd0;
      div_b_q   <= 32'd0;
      div_r_q   <= 32'd0;
      neg_quo_q <= 1'b0;
      neg_rem_q <= 1'b0;
      dz_q      <= 1'b0;
    end else begin
      cnt_q     <= cnt_d;
      div_a_q   <= div_a_d;
      div_b_q   <= div_b_d;
      div_r_q   <= div_r_d;
      neg_quo_q <= neg_quo_d;
      neg_rem_q <= neg_rem_d;
      dz_q      <= dz_d;
    end
  end

  logic [31:0] quo_s, rem_s, div_res_s, result_s;
  assign quo_s     = dz_q ? 32'hFFFF_FFFF : (neg_quo_q ? (32'd0 - div_a_q) : div_a_q);
  assign rem_s     = neg_rem_q ? (32'd0 - div_r_q) : div_r_q;
  assign div_res_s = is_mod_s ? rem_s : quo_s;
  assign result_s  = is_div_s ? div_res_s : (is_mul_s ? mul_res_s : alu_res_s);

  // Store lane enables and replicated write data
  always_comb begin
    data_sram_we    = 4'b0000;
    data_sram_wdata = rkd_s;
    if (sl_op_s[7]) begin
      data_sram_we    = 4'b1111;
      data_sram_wdata = rkd_s;
    end else if (sl_op_s[5]) begin
      data_sram_we    = sum_s[1] ? 4'b1100 : 4'b0011;
      data_sram_wdata = {2{rkd_s[15:0]}};
    end else if (sl_op_s[6]) begin
      data_sram_we    = 4'b0001 << sum_s[1:0];
      data_sram_wdata = {4{rkd_s[7:0]}};
    end else begin
      data_sram_we    = 4'b0000;
      data_sram_wdata = rkd_s;
    end
  end

  // mem_en from decode qualifies the access-type bits
  assign data_sram_en   = exe_valid_q & MEM_allowin & mem_en_s & (|sl_op_s);
  assign data_sram_addr = sum_s;

  assign EXE_to_MEM_BUS = {pc_s, gr_we_s, dest_s, result_s, sl_op_s[4:0], rfrom_mem_s, sum_s[1:0]};
  assign EXE_RF_BUS     = {((exe_valid_q & gr_we_s) ? dest_s : 5'd0),
                           rfrom_mem_s | (is_div_s & ~div_done_s),
                           result_s};

endmodule

// File: tb/tb_exe_stage.sv
// Testbench for exe_stage: vector table driven through a scoreboard plus
// directed handshake, divider-latency and reset sequences.
`timescale 1ns/1ps
module tb_exe_stage;

  logic         clk = 1'b0;
  logic         reset;
  logic [162:0] ID_to_EXE_BUS;
  logic         ID_to_EXE_valid;
  logic         EXE_allowin;
  logic         MEM_allowin;
  logic         EXE_to_MEM_valid;
  logic [77:0]  EXE_to_MEM_BUS;
  logic [37:0]  EXE_RF_BUS;
  logic         data_sram_en;
  logic [3:0]   data_sram_we;
  logic [31:0]  data_sram_addr;
  logic [31:0]  data_sram_wdata;

  exe_stage dut (
    .clk              (clk),
    .reset            (reset),
    .ID_to_EXE_BUS    (ID_to_EXE_BUS),
    .ID_to_EXE_valid  (ID_to_EXE_valid),
    .EXE_allowin      (EXE_allowin),
    .MEM_allowin      (MEM_allowin),
    .EXE_to_MEM_valid (EXE_to_MEM_valid),
    .EXE_to_MEM_BUS   (EXE_to_MEM_BUS),
    .EXE_RF_BUS       (EXE_RF_BUS),
    .data_sram_en     (data_sram_en),
    .data_sram_we     (data_sram_we),
    .data_sram_addr   (data_sram_addr),
    .data_sram_wdata  (data_sram_wdata)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [11:0] alu;
    logic [7:0]  sl;
    logic [6:0]  md;
    logic        rfm;
    logic [31:0] s1, s2, rkd, res;
    logic [3:0]  we;
    logic [31:0] wd;
  } vec_t;

  typedef struct {
    logic [77:0] bus;
    logic [37:0] rf;
    logic        en;
    logic [3:0]  we;
    logic [31:0] addr;
    logic [31:0] wd;
    logic        chk_wd;
  } exp_t;

  localparam int NV = 34;
  vec_t tv[NV];
  exp_t sb[$];
  exp_t mon_e;
  int   n_cmp = 0;
  int   n_err = 0;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  function automatic vec_t mkv(input logic [11:0] alu, input logic [7:0] sl, input logic [6:0] md,
                               input logic rfm, input logic [31:0] s1, input logic [31:0] s2,
                               input logic [31:0] rkd, input logic [31:0] res,
                               input logic [3:0] we, input logic [31:0] wd);
    vec_t v;
    v.alu = alu; v.sl = sl; v.md = md; v.rfm = rfm;
    v.s1 = s1; v.s2 = s2; v.rkd = rkd; v.res = res; v.we = we; v.wd = wd;
    return v;
  endfunction

  function automatic logic [162:0] mk_bus(input int i);
    vec_t v;
    logic gw;
    v  = tv[i];
    gw = (v.sl[7:5] == 3'b000);
    return {32'h1c00_0000 + 32'(i * 4), gw, 5'(i + 1), v.rkd, |v.sl, v.alu,
            v.s1, v.s2, v.sl, v.rfm, v.md};
  endfunction

  function automatic exp_t mk_exp(input int i);
    vec_t v;
    exp_t e;
    logic gw;
    logic [31:0] sum;
    logic [4:0] dst;
    v   = tv[i];
    gw  = (v.sl[7:5] == 3'b000);
    sum = v.s1 + v.s2;
    dst = 5'(i + 1);
    e.bus    = {32'h1c00_0000 + 32'(i * 4), gw, dst, v.res, v.sl[4:0], v.rfm, sum[1:0]};
    e.rf     = {(gw ? dst : 5'd0), v.rfm, v.res};
    e.en     = |v.sl;
    e.we     = v.we;
    e.addr   = sum;
    e.wd     = v.wd;
    e.chk_wd = |v.sl[7:5];
    return e;
  endfunction

  // Scoreboard: every handoff to MEM is checked against the oldest accepted instruction
  always @(negedge clk) begin
    if (!reset && EXE_to_MEM_valid && MEM_allowin) begin
      if (sb.size() == 0) begin
        n_cmp++;
        n_err++;
        $display("FAIL handoff_unexpected: got bus %0h, expected no handoff", EXE_to_MEM_BUS);
      end else begin
        mon_e = sb.pop_front();
        chk("mem_bus",   128'(EXE_to_MEM_BUS), 128'(mon_e.bus));
        chk("rf_bus",    128'(EXE_RF_BUS),     128'(mon_e.rf));
        chk("sram_en",   128'(data_sram_en),   128'(mon_e.en));
        chk("sram_we",   128'(data_sram_we),   128'(mon_e.we));
        chk("sram_addr", 128'(data_sram_addr), 128'(mon_e.addr));
        if (mon_e.chk_wd) chk("sram_wdata", 128'(data_sram_wdata), 128'(mon_e.wd));
      end
    end
  end

  task automatic send(input int i, input bit rnd);
    int guard;
    bit acc;
    ID_to_EXE_BUS   = mk_bus(i);
    ID_to_EXE_valid = 1'b1;
    guard = 0;
    acc   = 1'b0;
    while (!acc && guard < 200) begin
      if (rnd) MEM_allowin = ($urandom_range(0, 3) != 0);
      @(negedge clk);
      acc = EXE_allowin;
      if (acc) sb.push_back(mk_exp(i));
      @(posedge clk);
      #1;
      guard++;
    end
    if (!acc) begin
      n_cmp++;
      n_err++;
      $display("FAIL accept_timeout: vector %0d got no allowin, expected acceptance", i);
    end
    ID_to_EXE_valid = 1'b0;
  endtask

  task automatic drain();
    int guard;
    MEM_allowin = 1'b1;
    guard = 0;
    while (sb.size() != 0 && guard < 100) begin
      @(posedge clk);
      #1;
      guard++;
    end
    if (sb.size() != 0) begin
      n_cmp++;
      n_err++;
      $display("FAIL drain_timeout: got %0d pending, expected 0", sb.size());
      sb.delete();
    end
  endtask

  // Instruction resident at cycle 0 must become ready at cycle 33 exactly
  task automatic div_lat(input int i);
    MEM_allowin = 1'b1;
    send(i, 1'b0);
    for (int c = 0; c <= 33; c++) begin
      @(negedge clk);
      chk($sformatf("div_valid_c%0d", c), 128'(EXE_to_MEM_valid), 128'(c == 33));
      chk($sformatf("div_fwd_c%0d", c),   128'(EXE_RF_BUS[32]),   128'(c < 33));
      @(posedge clk);
      #1;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: time limit reached, expected completion");
    $fatal(1);
  end

  initial begin
    exp_t e;
    tv[0]  = mkv(12'h001, 8'h00, 7'h00, 1'b0, 32'd5,         32'd7,         32'd0, 32'd12,        4'h0, 32'd0);
    tv[1]  = mkv(12'h002, 8'h00, 7'h00, 1'b0, 32'd5,         32'd7,         32'd0, 32'hFFFF_FFFE, 4'h0, 32'd0);
    tv[2]  = mkv(12'h004, 8'h00, 7'h00, 1'b0, 32'hFFFF_FFFF, 32'd1,         32'd0, 32'd1,         4'h0, 32'd0);
    tv[3]  = mkv(12'h008, 8'h00, 7'h00, 1'b0, 32'hFFFF_FFFF, 32'd1,         32'd0, 32'd0,         4'h0, 32'd0);
    tv[4]  = mkv(12'h010, 8'h00, 7'h00, 1'b0, 32'hF0F0_F0F0, 32'hFF00_FF00, 32'd0, 32'hF000_F000, 4'h0, 32'd0);
    tv[5]  = mkv(12'h020, 8'h00, 7'h00, 1'b0, 32'hF0F0_F0F0, 32'hFF00_FF00, 32'd0, 32'h000F_000F, 4'h0, 32'd0);
    tv[6]  = mkv(12'h040, 8'h00, 7'h00, 1'b0, 32'hF0F0_F0F0, 32'hFF00_FF00, 32'd0, 32'hFFF0_FFF0, 4'h0, 32'd0);
    tv[7]  = mkv(12'h080, 8'h00, 7'h00, 1'b0, 32'hF0F0_F0F0, 32'hFF00_FF00, 32'd0, 32'h0FF0_0FF0, 4'h0, 32'd0);
    tv[8]  = mkv(12'h100, 8'h00, 7'h00, 1'b0, 32'h8000_0001, 32'h0000_0021, 32'd0, 32'h0000_0002, 4'h0, 32'd0);
    tv[9]  = mkv(12'h200, 8'h00, 7'h00, 1'b0, 32'h8000_0000, 32'd4,         32'd0, 32'h0800_0000, 4'h0, 32'd0);
    tv[10] = mkv(12'h400, 8'h00, 7'h00, 1'b0, 32'h8000_0000, 32'd4,         32'd0, 32'hF800_0000, 4'h0, 32'd0);
    tv[11] = mkv(12'h800, 8'h00, 7'h00, 1'b0, 32'h0000_DEAD, 32'h1234_5000, 32'd0, 32'h1234_5000, 4'h0, 32'd0);
    tv[12] = mkv(12'h000, 8'h00, 7'h40, 1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd0, 32'd1,         4'h0, 32'd0);
    tv[13] = mkv(12'h000, 8'h00, 7'h20, 1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd0, 32'd0,         4'h0, 32'd0);
    tv[14] = mkv(12'h000, 8'h00, 7'h10, 1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd0, 32'hFFFF_FFFE, 4'h0, 32'd0);
    tv[15] = mkv(12'h000, 8'h00, 7'h20, 1'b0, 32'h8000_0000, 32'd2,         32'd0, 32'hFFFF_FFFF, 4'h0, 32'd0);
    tv[16] = mkv(12'h000, 8'h00, 7'h08, 1'b0, 32'hFFFF_FFF9, 32'd2,         32'd0, 32'hFFFF_FFFD, 4'h0, 32'd0);
    tv[17] = mkv(12'h000, 8'h00, 7'h04, 1'b0, 32'hFFFF_FFF9, 32'd2,         32'd0, 32'hFFFF_FFFF, 4'h0, 32'd0);
    tv[18] = mkv(12'h000, 8'h00, 7'h02, 1'b0, 32'd9,         32'd0,         32'd0, 32'hFFFF_FFFF, 4'h0, 32'd0);
    tv[19] = mkv(12'h000, 8'h00, 7'h01, 1'b0, 32'd9,         32'd0,         32'd0, 32'd9,         4'h0, 32'd0);
    tv[20] = mkv(12'h000, 8'h00, 7'h08, 1'b0, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 32'h8000_0000, 4'h0, 32'd0);
    tv[21] = mkv(12'h000, 8'h00, 7'h04, 1'b0, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 32'd0,         4'h0, 32'd0);
    tv[22] = mkv(12'h000, 8'h00, 7'h02, 1'b0, 32'hFFFF_FFF9, 32'd2,         32'd0, 32'h7FFF_FFFC, 4'h0, 32'd0);
    tv[23] = mkv(12'h000, 8'h00, 7'h04, 1'b0, 32'd7,         32'hFFFF_FFFE, 32'd0, 32'd1,         4'h0, 32'd0);
    tv[24] = mkv(12'h000, 8'h00, 7'h08, 1'b0, 32'd100,       32'hFFFF_FFF9, 32'd0, 32'hFFFF_FFF2, 4'h0, 32'd0);
    tv[25] = mkv(12'h000, 8'h00, 7'h04, 1'b0, 32'hFFFF_FFFB, 32'd0,         32'd0, 32'hFFFF_FFFB, 4'h0, 32'd0);
    tv[26] = mkv(12'h001, 8'h40, 7'h00, 1'b0, 32'h1000,      32'd3,  32'h0000_00AB, 32'h1003, 4'b1000, 32'hABAB_ABAB);
    tv[27] = mkv(12'h001, 8'h40, 7'h00, 1'b0, 32'h1000,      32'd1,  32'h0000_005A, 32'h1001, 4'b0010, 32'h5A5A_5A5A);
    tv[28] = mkv(12'h001, 8'h20, 7'h00, 1'b0, 32'h1000,      32'd2,  32'h0000_1234, 32'h1002, 4'b1100, 32'h1234_1234);
    tv[29] = mkv(12'h001, 8'h20, 7'h00, 1'b0, 32'h1000,      32'd0,  32'h0000_5678, 32'h1000, 4'b0011, 32'h5678_5678);
    tv[30] = mkv(12'h001, 8'h80, 7'h00, 1'b0, 32'h2000,      32'd4,  32'hDEAD_BEEF, 32'h2004, 4'b1111, 32'hDEAD_BEEF);
    tv[31] = mkv(12'h001, 8'h10, 7'h00, 1'b1, 32'h3000,      32'd1,  32'd0,         32'h3001, 4'b0000, 32'd0);
    tv[32] = mkv(12'h001, 8'h02, 7'h00, 1'b1, 32'h3000,      32'd6,  32'd0,         32'h3006, 4'b0000, 32'd0);
    tv[33] = mkv(12'h001, 8'h08, 7'h00, 1'b1, 32'h3000,      32'd7,  32'd0,         32'h3007, 4'b0000, 32'd0);

    reset           = 1'b1;
    ID_to_EXE_valid = 1'b0;
    ID_to_EXE_BUS   = '0;
    MEM_allowin     = 1'b0;
    #12;
    chk("rst_allowin",  128'(EXE_allowin),      128'(1));
    chk("rst_valid",    128'(EXE_to_MEM_valid), 128'(0));
    chk("rst_mem_bus",  128'(EXE_to_MEM_BUS),   128'(0));
    chk("rst_rf_bus",   128'(EXE_RF_BUS),       128'(0));
    chk("rst_en",       128'(data_sram_en),     128'(0));
    chk("rst_we",       128'(data_sram_we),     128'(0));
    chk("rst_addr",     128'(data_sram_addr),   128'(0));
    chk("rst_wdata",    128'(data_sram_wdata),  128'(0));
    @(posedge clk);
    #1;
    reset = 1'b0;

    // basic handshake: add 5+7 hands off the cycle after acceptance
    MEM_allowin = 1'b1;
    send(0, 1'b0);
    @(negedge clk);
    chk("hs_valid", 128'(EXE_to_MEM_valid), 128'(1));
    chk("hs_rf",    128'(EXE_RF_BUS),       128'({5'd1, 1'b0, 32'd12}));
    @(posedge clk);
    #1;
    @(negedge clk);
    chk("hs_idle_valid", 128'(EXE_to_MEM_valid), 128'(0));
    @(posedge clk);
    #1;

    // back-pressure: held bundle, then release hands off in the same cycle
    send(1, 1'b0);
    MEM_allowin = 1'b0;
    e = mk_exp(1);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk("bp_allowin", 128'(EXE_allowin),      128'(0));
      chk("bp_valid",   128'(EXE_to_MEM_valid), 128'(1));
      chk("bp_bus",     128'(EXE_to_MEM_BUS),   128'(e.bus));
      @(posedge clk);
      #1;
    end
    MEM_allowin = 1'b1;
    @(negedge clk);
    chk("bp_release_allowin", 128'(EXE_allowin), 128'(1));
    @(posedge clk);
    #1;

    div_lat(16);
    div_lat(17);
    div_lat(18);

    // async reset in the middle of a divide
    MEM_allowin = 1'b1;
    send(18, 1'b0);
    repeat (10) begin
      @(posedge clk);
      #1;
    end
    #2;
    reset = 1'b1;
    #1;
    chk("mid_rst_allowin", 128'(EXE_allowin),      128'(1));
    chk("mid_rst_valid",   128'(EXE_to_MEM_valid), 128'(0));
    chk("mid_rst_rf",      128'(EXE_RF_BUS),       128'(0));
    chk("mid_rst_bus",     128'(EXE_to_MEM_BUS),   128'(0));
    sb.delete();
    @(posedge clk);
    #1;
    reset = 1'b0;
    div_lat(18);

    for (int i = 0; i < NV; i++) send(i, 1'b1);
    drain();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
